rsm_memarb: RTL

Arbitrates the RV32I core's instruction-fetch AXI4-Lite read port (IFU) and load/store AXI4-Lite read/write ports (LSU) onto one single-port memory request interface. It replaces the "one access at a time" assumption at the core/memory boundary, so IFU and LSU may request concurrently. One transaction is outstanding at a time. A watchdog converts a missing memory reply into an error response.

---
 rtl/rsm_memarb.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/rsm_memarb.sv
// Arbitrates IFU reads and LSU reads/writes onto one single-port memory request bus,
// one transaction at a time, with a reply watchdog. Define RSM_MEMARB_RR_EN for round-robin IFU/LSU.
module rsm_memarb #(
  parameter int TIMEOUT_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_axi_ifu_araddr,
  input  logic [2:0]  i_axi_ifu_arprot,
  input  logic        i_axi_ifu_arvalid,
  output logic        o_axi_ifu_arready,
  output logic [31:0] o_axi_ifu_rdata,
  output logic [1:0]  o_axi_ifu_rresp,
  output logic        o_axi_ifu_rvalid,
  input  logic        i_axi_ifu_rready,
  input  logic [31:0] i_axi_lsu_awaddr,
  input  logic [2:0]  i_axi_lsu_awprot,
  input  logic        i_axi_lsu_awvalid,
  output logic        o_axi_lsu_awready,
  input  logic [31:0] i_axi_lsu_wdata,
  input  logic [3:0]  i_axi_lsu_wstrb,
  input  logic        i_axi_lsu_wvalid,
  output logic        o_axi_lsu_wready,
  output logic [1:0]  o_axi_lsu_bresp,
  output logic        o_axi_lsu_bvalid,
  input  logic        i_axi_lsu_bready,
  input  logic [31:0] i_axi_lsu_araddr,
  input  logic [2:0]  i_axi_lsu_arprot,
  input  logic        i_axi_lsu_arvalid,
  output logic        o_axi_lsu_arready,
  output logic [31:0] o_axi_lsu_rdata,
  output logic [1:0]  o_axi_lsu_rresp,
  output logic        o_axi_lsu_rvalid,
  input  logic        i_axi_lsu_rready,
  output logic        o_mem_valid,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SRC_IFU_RD, SRC_LSU_RD, SRC_LSU_WR} src_t;

  state_t               state_q, state_d;
  src_t                 src_q, src_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          ifu_rdata_q, ifu_rdata_d;
  logic [1:0]           ifu_rresp_q, ifu_rresp_d;
  logic [31:0]          lsu_rdata_q, lsu_rdata_d;
  logic [1:0]           lsu_rresp_q, lsu_rresp_d;
  logic [1:0]           bresp_q, bresp_d;
  // Holds off grants for the first cycle after reset so readies are 0 while i_rstn is low.
  logic                 run_q;

  logic ifu_req, lsu_wr_req, lsu_rd_req, lsu_req, grant_lsu;
  logic load_resp;
  logic [31:0] resp_data;
  logic [1:0]  resp_code;

  logic unused_prot;
  assign unused_prot = ^{i_axi_ifu_arprot, i_axi_lsu_awprot, i_axi_lsu_arprot};

  assign ifu_req    = i_axi_ifu_arvalid;
  assign lsu_wr_req = i_axi_lsu_awvalid && i_axi_lsu_wvalid;
  assign lsu_rd_req = i_axi_lsu_arvalid;
  assign lsu_req    = lsu_wr_req || lsu_rd_req;

`ifdef RSM_MEMARB_RR_EN
  logic last_lsu_q, last_lsu_d;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) last_lsu_q <= 1'b0;
    else         last_lsu_q <= last_lsu_d;
  end

  // On contention the master that was not granted last wins.
  assign grant_lsu = lsu_req && (!ifu_req || !last_lsu_q);

  always_comb begin
    last_lsu_d = last_lsu_q;
    if (state_q == IDLE && run_q && (ifu_req || lsu_req)) last_lsu_d = grant_lsu;
  end
`else
  assign grant_lsu = lsu_req;
`endif

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    ifu_rdata_d = ifu_rdata_q;
    ifu_rresp_d = ifu_rresp_q;
    lsu_rdata_d = lsu_rdata_q;
    lsu_rresp_d = lsu_rresp_q;
    bresp_d     = bresp_q;
    load_resp   = 1'b0;
    resp_data   = 32'd0;
    resp_code   = 2'b00;
    o_axi_ifu_arready = 1'b0;
    o_axi_lsu_arready = 1'b0;
    o_axi_lsu_awready = 1'b0;
    o_axi_lsu_wready  = 1'b0;

    case (state_q)
      IDLE: begin
        if (run_q && (ifu_req || lsu_req)) begin
          state_d = REQ;
          if (grant_lsu && lsu_wr_req) begin
            o_axi_lsu_awready = 1'b1;
            o_axi_lsu_wready  = 1'b1;
            src_d   = SRC_LSU_WR;
            addr_d  = i_axi_lsu_awaddr;
            wdata_d = i_axi_lsu_wdata;
            wstrb_d = i_axi_lsu_wstrb;
          end else if (grant_lsu) begin
            o_axi_lsu_arready = 1'b1;
            src_d   = SRC_LSU_RD;
            addr_d  = i_axi_lsu_araddr;
            wdata_d = 32'd0;
            wstrb_d = 4'd0;
          end else begin
            o_axi_ifu_arready = 1'b1;
            src_d   = SRC_IFU_RD;
            addr_d  = i_axi_ifu_araddr;
            wdata_d = 32'd0;
            wstrb_d = 4'd0;
          end
        end
      end
      REQ: begin
        if (i_mem_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        // A real reply takes precedence over a watchdog expiry in the same cycle.
        if (i_mem_rvalid) begin
          load_resp = 1'b1;
          resp_data = i_mem_rdata;
          resp_code = i_mem_err ? 2'b11 : 2'b00;
        end else if (cnt_q == {TIMEOUT_W{1'b1}}) begin
          load_resp = 1'b1;
          resp_data = 32'd0;
          resp_code = 2'b10;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (load_resp) begin
          state_d = RESP;
          case (src_q)
            SRC_IFU_RD: begin
              ifu_rdata_d = resp_data;
              ifu_rresp_d = resp_code;
            end
            SRC_LSU_RD: begin
              lsu_rdata_d = resp_data;
              lsu_rresp_d = resp_code;
            end
            default: bresp_d = resp_code;
          endcase
        end
      end
      RESP: begin
        case (src_q)
          SRC_IFU_RD: if (i_axi_ifu_rready) state_d = IDLE;
          SRC_LSU_RD: if (i_axi_lsu_rready) state_d = IDLE;
          default:    if (i_axi_lsu_bready) state_d = IDLE;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      src_q       <= SRC_IFU_RD;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      cnt_q       <= '0;
      ifu_rdata_q <= 32'd0;
      ifu_rresp_q <= 2'b00;
      lsu_rdata_q <= 32'd0;
      lsu_rresp_q <= 2'b00;
      bresp_q     <= 2'b00;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      cnt_q       <= cnt_d;
      ifu_rdata_q <= ifu_rdata_d;
      ifu_rresp_q <= ifu_rresp_d;
      lsu_rdata_q <= lsu_rdata_d;
      lsu_rresp_q <= lsu_rresp_d;
      bresp_q     <= bresp_d;
      run_q       <= 1'b1;
    end
  end

  assign o_mem_valid = (state_q == REQ);
  assign o_mem_addr  = addr_q;
  assign o_mem_wstrb = wstrb_q;
  assign o_mem_wdata = wdata_q;

  assign o_axi_ifu_rvalid = (state_q == RESP) && (src_q == SRC_IFU_RD);
  assign o_axi_lsu_rvalid = (state_q == RESP) && (src_q == SRC_LSU_RD);
  assign o_axi_lsu_bvalid = (state_q == RESP) && (src_q == SRC_LSU_WR);
  assign o_axi_ifu_rdata  = ifu_rdata_q;
  assign o_axi_ifu_rresp  = ifu_rresp_q;
  assign o_axi_lsu_rdata  = lsu_rdata_q;
  assign o_axi_lsu_rresp  = lsu_rresp_q;
  assign o_axi_lsu_bresp  = bresp_q;

endmodule
